// File: rtl/counter_mod_pkg.sv
// Shared constants and helpers for the modulo-N up-counter.
// The defaults describe a seconds/minutes style divider (0..59 in six bits).
package counter_mod_pkg;

   localparam int DEFAULT_WIDTH   = 6;
   localparam int DEFAULT_MODULUS = 60;

   // A modulus is usable only if it has at least two states and its
   // terminal value MODULUS-1 still fits in the count register.
   function automatic bit modulus_legal(input int width, input int modulus);
      longint unsigned capacity;
      capacity = longint'(1) << width;
      return (modulus >= 2) && (longint'(modulus) <= capacity);
   endfunction

endpackage : counter_mod_pkg

// File: rtl/counter_mod.sv
// Free-running modulo-N up-counter with synchronous active-high reset.
// The output is the state register itself, so there is no combinational path
// from state to count and a new value appears one edge after it is computed.
module counter_mod
   import counter_mod_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = DEFAULT_MODULUS
) (
   output logic [WIDTH-1:0] count,
   input  logic             clk,
   input  logic             rst
);

   // Terminal value; anything at or above it wraps back to zero, so a state
   // corrupted out of range (upset, X resolution) re-enters the legal range.
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   // Reject parameter combinations that cannot represent the full cycle.
   if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("counter_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   // Next-state: wrap at (or beyond) the terminal value, otherwise increment.
   // The increment cannot overflow because LAST never exceeds 2**WIDTH-1.
   always_comb begin
      count_next = count_reg + WIDTH'(1);
      if (count_reg >= LAST) begin
         count_next = '0;
      end
   end

   // State register; reset takes priority over counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule : counter_mod

// File: tb/tb_counter_mod.sv
// Directed, table-driven bench for counter_mod (default modulo-60) with two
// extra instances covering the MODULUS=2 and MODULUS=64 extremes.
module tb_counter_mod;

   logic       clk;
   logic       rst;
   logic [5:0] count;
   logic [5:0] count_m2;
   logic [5:0] count_m64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [5:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   counter_mod dut (
      .count (count),
      .clk   (clk),
      .rst   (rst)
   );

   counter_mod #(.WIDTH(6), .MODULUS(2)) dut_m2 (
      .count (count_m2),
      .clk   (clk),
      .rst   (rst)
   );

   counter_mod #(.WIDTH(6), .MODULUS(64)) dut_m64 (
      .count (count_m64),
      .clk   (clk),
      .rst   (rst)
   );

   // 10 ns clock starting low: rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d",
                  name, $time, actual, expected);
      end
   endtask

   // Drive rst at a falling edge, let one rising edge pass, return at the next
   // falling edge so outputs are sampled well away from the active edge.
   task automatic applyStimulus(input logic r);
      rst = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Independent per-cycle reference for the sweep instances.
   function automatic int ref_next(input int c, input int m, input logic r);
      if (r) return 0;
      return (c >= m - 1) ? 0 : c + 1;
   endfunction

   initial begin
      int m2;
      int m64;
      int e;

      // Vector table: count 1..59, wrap to 0, continue up to 37, then a
      // mid-count reset held for three edges, then release.
      e = 0;
      for (int i = 0; i < 97; i++) begin
         e = (e == 59) ? 0 : e + 1;
         vecs.push_back('{rst: 1'b0, exp_count: 6'(e)});
      end
      vecs.push_back('{rst: 1'b1, exp_count: 6'd0});
      vecs.push_back('{rst: 1'b1, exp_count: 6'd0});
      vecs.push_back('{rst: 1'b1, exp_count: 6'd0});
      vecs.push_back('{rst: 1'b0, exp_count: 6'd1});
      vecs.push_back('{rst: 1'b0, exp_count: 6'd2});
      vecs.push_back('{rst: 1'b0, exp_count: 6'd3});

      // Reset for the single edge at 15 ns (rst high 10..20 ns).
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(1'b1);
      checkOutput("reset_count", {2'b00, count}, 8'd0);
      checkOutput("reset_m2", {2'b00, count_m2}, 8'd0);
      checkOutput("reset_m64", {2'b00, count_m64}, 8'd0);
      m2  = 0;
      m64 = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst);
         checkOutput($sformatf("vec%0d", i), {2'b00, count},
                     {2'b00, vecs[i].exp_count});
         if ($time == 520) begin
            checkOutput("count_at_515ns", {2'b00, count}, 8'd50);
         end
         m2  = ref_next(m2, 2, vecs[i].rst);
         m64 = ref_next(m64, 64, vecs[i].rst);
         checkOutput($sformatf("m2_vec%0d", i), {2'b00, count_m2}, 8'(m2));
         checkOutput($sformatf("m64_vec%0d", i), {2'b00, count_m64}, 8'(m64));
      end

      // The 37 -> reset transition must land on 0 the very next edge.
      checkOutput("table_hit_37", {2'b00, vecs[96].exp_count}, 8'd37);

      // Out-of-range states must wrap to zero rather than keep counting.
      force dut.count_reg = 6'd62;
      #1;
      checkOutput("oor_62_next", {2'b00, dut.count_next}, 8'd0);
      force dut.count_reg = 6'd63;
      #1;
      checkOutput("oor_63_next", {2'b00, dut.count_next}, 8'd0);
      force dut.count_reg = 6'd59;
      #1;
      checkOutput("terminal_59_next", {2'b00, dut.count_next}, 8'd0);
      force dut.count_reg = 6'd58;
      #1;
      checkOutput("pre_terminal_58_next", {2'b00, dut.count_next}, 8'd59);
      release dut.count_reg;

      // Recover cleanly through reset and confirm counting resumes.
      @(negedge clk);
      applyStimulus(1'b1);
      checkOutput("post_force_reset", {2'b00, count}, 8'd0);
      applyStimulus(1'b0);
      checkOutput("post_force_count1", {2'b00, count}, 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] timeout");
   end

endmodule : tb_counter_mod
